// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator clocked by refclk. When the addition
// carries, that channel's ce output gives a one-cycle pulse. Increments are
// written to a shadow register and take effect at a period boundary, so a
// retune never produces a runt pulse.
// Ports:
//   refclk   - sole clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   inc      - new increment per channel, channel i at [i*ACC_W +: ACC_W]
//   inc_load - per-channel strobe capturing the inc slice into the shadow
//   en       - per-channel run enable
//   sync     - one-cycle strobe, zeroes all accumulators (phase align)
//   ce       - registered clock-enable pulses
//   locked   - high once the lock count has elapsed; ce is valid
module clken_gen #(
    parameter int unsigned                  CHANNELS    = 3,
    parameter int unsigned                  ACC_W       = 24,
    parameter logic [CHANNELS*ACC_W-1:0]    INC_INIT    = {24'd1048576, 24'd8388608, 24'd570425},
    parameter int unsigned                  LOCK_CYCLES = 16,
    parameter bit                           RELOCK      = 1'b0
) (
    input  logic                       refclk,
    input  logic                       rst_n,
    input  logic [CHANNELS*ACC_W-1:0]  inc,
    input  logic [CHANNELS-1:0]        inc_load,
    input  logic [CHANNELS-1:0]        en,
    input  logic                       sync,
    output logic [CHANNELS-1:0]        ce,
    output logic                       locked
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [1:0]        rst_sync;
    logic              rst_ok;
    logic [LOCK_W-1:0] lock_cnt;
    logic              relock_trig;

    // Two-flop synchroniser on reset release; the lock count waits for it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_ok      = rst_sync[1];
    assign relock_trig = RELOCK && (|inc_load);

    // Lock counter: locked rises on the edge the count reaches LOCK_CYCLES.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (relock_trig) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (rst_ok && !locked) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
            if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                locked <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] act;
        logic [ACC_W-1:0] shd;
        logic             pnd;
        logic             ce_q;
        logic [ACC_W:0]   sum;
        logic [ACC_W-1:0] slice;
        logic             run;
        logic             carry;
        logic             apply;

        assign slice = inc[i*ACC_W +: ACC_W];
        assign sum   = {1'b0, acc} + {1'b0, act};
        assign run   = locked & en[i];
        assign carry = run & sum[ACC_W];
        // Pending increment lands on a period boundary or while idle.
        assign apply = pnd & (carry | ~en[i]);

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                acc  <= '0;
                act  <= INC_INIT[i*ACC_W +: ACC_W];
                shd  <= INC_INIT[i*ACC_W +: ACC_W];
                pnd  <= 1'b0;
                ce_q <= 1'b0;
            end else if (sync) begin
                // Phase align: a same-edge load wins over the older shadow.
                acc  <= '0;
                ce_q <= 1'b0;
                pnd  <= 1'b0;
                if (inc_load[i]) begin
                    act <= slice;
                    shd <= slice;
                end else if (pnd) begin
                    act <= shd;
                end
            end else begin
                ce_q <= carry;
                if (run) begin
                    acc <= sum[ACC_W-1:0];
                end
                if (apply) begin
                    act <= shd;
                end
                // A load on the applying edge stays pending for the next boundary.
                if (inc_load[i]) begin
                    shd <= slice;
                    pnd <= 1'b1;
                end else if (apply) begin
                    pnd <= 1'b0;
                end
            end
        end

        assign ce[i] = ce_q;
    end

endmodule
